// File: rtl/game_vga_pkg.sv
// game_vga_pkg: default VGA timing, derived totals/sync positions and checker state encoding
package game_vga_pkg;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_BOTTOM  = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_TOP     = 33;
    localparam int DEF_H_SYNC_START = DEF_H_DISPLAY + DEF_H_FRONT;
    localparam int DEF_H_SYNC_END   = DEF_H_SYNC_START + DEF_H_SYNC;
    localparam int DEF_V_SYNC_START = DEF_V_DISPLAY + DEF_V_BOTTOM;
    localparam int DEF_V_SYNC_END   = DEF_V_SYNC_START + DEF_V_SYNC;

    function automatic int h_total(int display, int front, int sync, int back);
        return display + front + sync + back;
    endfunction

    function automatic int v_total(int display, int bottom, int sync, int top);
        return display + bottom + sync + top;
    endfunction

    typedef enum logic [1:0] {SEARCH, H_ACQ, V_ACQ, LOCKED} vga_state_t;
endpackage

// File: rtl/game_sync_edge.sv
// game_sync_edge: registers a sync input as an active flag and flags its assert/deassert edges
module game_sync_edge #(
    parameter logic ACTIVE = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic sync,
    output logic assert_edge,
    output logic deassert_edge
);
    logic cur, prev;

    always_ff @(posedge clk) begin
        if (!reset) begin
            cur  <= 1'b0;
            prev <= 1'b0;
        end else begin
            cur  <= sync == ACTIVE;
            prev <= cur;
        end
    end

    assign assert_edge   = cur & ~prev;
    assign deassert_edge = ~cur & prev;
endmodule

// File: rtl/game_vga_timing_checker.sv
// game_vga_timing_checker: locks onto hsync/vsync, recovers x/y and flags VGA timing violations
module game_vga_timing_checker
    import game_vga_pkg::*;
#(
    parameter int X_WIDTH     = 10,
    parameter int Y_WIDTH     = 10,
    parameter int H_DISPLAY   = DEF_H_DISPLAY,
    parameter int H_FRONT     = DEF_H_FRONT,
    parameter int H_SYNC      = DEF_H_SYNC,
    parameter int H_BACK      = DEF_H_BACK,
    parameter int V_DISPLAY   = DEF_V_DISPLAY,
    parameter int V_BOTTOM    = DEF_V_BOTTOM,
    parameter int V_SYNC      = DEF_V_SYNC,
    parameter int V_TOP       = DEF_V_TOP,
    parameter int SYNC_ACTIVE = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hsync,
    input  logic               vsync,
    input  logic [2:0]         rgb,
    input  logic               clear_errors,
    output logic               locked,
    output logic [X_WIDTH-1:0] x,
    output logic [Y_WIDTH-1:0] y,
    output logic               pixel_valid,
    output logic [2:0]         rgb_out,
    output logic               frame_start,
    output logic               h_error,
    output logic               v_error,
    output logic [7:0]         error_count,
    output logic [15:0]        frame_count
);
    localparam logic [X_WIDTH-1:0] H_LAST = X_WIDTH'(h_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK) - 1);
    localparam logic [X_WIDTH-1:0] H_SS   = X_WIDTH'(H_DISPLAY + H_FRONT);
    localparam logic [X_WIDTH-1:0] H_SE   = X_WIDTH'(H_DISPLAY + H_FRONT + H_SYNC);
    localparam logic [X_WIDTH-1:0] H_VIS  = X_WIDTH'(H_DISPLAY);
    localparam logic [Y_WIDTH-1:0] V_LAST = Y_WIDTH'(v_total(V_DISPLAY, V_BOTTOM, V_SYNC, V_TOP) - 1);
    localparam logic [Y_WIDTH-1:0] V_SS   = Y_WIDTH'(V_DISPLAY + V_BOTTOM);
    localparam logic [Y_WIDTH-1:0] V_SE   = Y_WIDTH'(V_DISPLAY + V_BOTTOM + V_SYNC);
    localparam logic [Y_WIDTH-1:0] V_VIS  = Y_WIDTH'(V_DISPLAY);

    vga_state_t state, state_next;
    logic h_on, h_off, v_on, v_off, v_inc, line_ok, h_viol, v_viol, h_err, v_err, fs, pv;
    logic [2:0] rgb_q;
    logic [X_WIDTH-1:0] hcnt, h_free, h_pos;
    logic [Y_WIDTH-1:0] vcnt, v_free, v_pos;

    game_sync_edge #(.ACTIVE(1'(SYNC_ACTIVE))) u_hsync (
        .clk(clk), .reset(reset), .sync(hsync), .assert_edge(h_on), .deassert_edge(h_off)
    );
    game_sync_edge #(.ACTIVE(1'(SYNC_ACTIVE))) u_vsync (
        .clk(clk), .reset(reset), .sync(vsync), .assert_edge(v_on), .deassert_edge(v_off)
    );

    // hcnt/vcnt hold the position of the previous sample; h_pos/v_pos are the current one
    always_comb begin
        h_free = (hcnt == H_LAST) ? '0 : hcnt + 1'b1;
        h_pos  = h_on ? H_SS : h_free;
        v_inc  = !h_on && hcnt == H_LAST;
        v_free = v_inc ? ((vcnt == V_LAST) ? '0 : vcnt + 1'b1) : vcnt;
        v_pos  = v_on ? V_SS : v_free;
        h_viol = (h_on != (h_free == H_SS)) || (h_off && h_pos != H_SE);
        v_viol = (v_on != (v_inc && v_free == V_SS)) || (v_off && v_pos != V_SE);
    end

    always_ff @(posedge clk) begin
        if (!reset) state <= SEARCH;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            SEARCH:  state_next = h_on ? H_ACQ : SEARCH;
            H_ACQ:   state_next = (h_on && line_ok && !h_viol) ? V_ACQ : H_ACQ;
            V_ACQ:   state_next = h_viol ? H_ACQ : v_on ? LOCKED : V_ACQ;
            LOCKED:  state_next = h_viol ? SEARCH : v_viol ? V_ACQ : LOCKED;
            default: state_next = SEARCH;
        endcase
    end

    always_comb begin
        h_err = state == LOCKED && h_viol;
        v_err = state == LOCKED && v_viol;
        fs    = state == LOCKED && v_on;
        pv    = state == LOCKED && h_pos < H_VIS && v_pos < V_VIS;
    end

    // line_ok: a trial line has started at an hsync edge and seen no violation yet
    always_ff @(posedge clk) begin
        if (!reset) begin
            hcnt        <= '0;
            vcnt        <= '0;
            line_ok     <= 1'b0;
            rgb_q       <= '0;
            pixel_valid <= 1'b0;
            rgb_out     <= '0;
            frame_start <= 1'b0;
            h_error     <= 1'b0;
            v_error     <= 1'b0;
        end else begin
            hcnt        <= h_pos;
            vcnt        <= v_pos;
            line_ok     <= h_on || (line_ok && !h_viol);
            rgb_q       <= rgb;
            pixel_valid <= pv;
            rgb_out     <= pv ? rgb_q : '0;
            frame_start <= fs;
            h_error     <= h_err;
            v_error     <= v_err;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) error_count <= '0;
        else if (clear_errors) error_count <= {7'd0, h_error | v_error};
        else if ((h_error || v_error) && error_count != 8'hff) error_count <= error_count + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) frame_count <= '0;
        else if (frame_start) frame_count <= frame_count + 1'b1;
    end

    assign locked = state == LOCKED;
    assign x      = hcnt;
    assign y      = vcnt;
endmodule

// File: tb/tb_game_vga_timing_checker.sv
// tb_game_vga_timing_checker: drives a small-timing hvsync stream with injected faults into the checker
module tb_game_vga_timing_checker;
    localparam int HD = 8, HF = 2, HS = 3, HB = 3;
    localparam int VD = 4, VB = 1, VS = 2, VT = 2;
    localparam int HTOT = HD + HF + HS + HB;
    localparam int VTOT = VD + VB + VS + VT;
    localparam int HSS = HD + HF;
    localparam int VSS = VD + VB;
    localparam int VSE = VSS + VS;

    logic clk = 1'b0, reset = 1'b0, hsync = 1'b1, vsync = 1'b1, clear_errors = 1'b0;
    logic [2:0] rgb = 3'd0;
    logic locked, pixel_valid, frame_start, h_error, v_error;
    logic [9:0] x, y;
    logic [2:0] rgb_out;
    logic [7:0] error_count;
    logic [15:0] frame_count;

    int checks = 0, errors = 0;
    int gx = 0, gy = 0, hs_len = HS, line_len = HTOT, frame_len = VTOT;
    int px = 0, py = 0, pc = 0, ex = 0, ey = 0, ec = 0;
    int he_n = 0, ve_n = 0, pv_n = 0, n = 0, pv_e = 0;

    game_vga_timing_checker #(
        .X_WIDTH(10), .Y_WIDTH(10),
        .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_DISPLAY(VD), .V_BOTTOM(VB), .V_SYNC(VS), .V_TOP(VT),
        .SYNC_ACTIVE(0)
    ) dut (
        .clk(clk), .reset(reset), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .clear_errors(clear_errors), .locked(locked), .x(x), .y(y),
        .pixel_valid(pixel_valid), .rgb_out(rgb_out), .frame_start(frame_start),
        .h_error(h_error), .v_error(v_error), .error_count(error_count),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, int got, int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // one pixel clock: ex/ey/ec become the generator sample the outputs now refer to
    task automatic step();
        @(negedge clk);
        ex = px; ey = py; ec = pc;
        px = gx; py = gy; pc = int'(rgb);
        he_n += int'(h_error);
        ve_n += int'(v_error);
        if (gx == line_len - 1) begin
            gx = 0;
            gy = (gy == frame_len - 1) ? 0 : gy + 1;
        end else gx++;
        hsync = !(gx >= HSS && gx < HSS + hs_len);
        vsync = !(gy >= VSS && gy < VSE);
        rgb   = 3'(gx + 2 * gy);
    endtask

    task automatic run_to(int tx, int ty);
        int k = 0;
        while (!(gx == tx && gy == ty) && k < 4 * HTOT * VTOT) begin
            step();
            k++;
        end
        check("run_to", int'(gx == tx && gy == ty), 1);
    endtask

    task automatic wait_lock(string tag);
        int k = 0;
        while (!locked && k < 4 * HTOT * VTOT) begin
            step();
            k++;
        end
        check({tag, "_locked"}, int'(locked), 1);
        check({tag, "_lock_x"}, ex, 0);
        check({tag, "_lock_y"}, ey, VSS);
        check({tag, "_x"}, int'(x), 0);
        check({tag, "_y"}, int'(y), VSS);
    endtask

    task automatic short_hsync_line1();
        run_to(0, 1);
        hs_len = HS - 1;
        run_to(0, 2);
        hs_len = HS;
    endtask

    initial begin
        repeat (4) step();
        check("rst_locked", int'(locked), 0);
        check("rst_x", int'(x), 0);
        check("rst_y", int'(y), 0);
        check("rst_pv", int'(pixel_valid), 0);
        check("rst_rgb", int'(rgb_out), 0);
        check("rst_errs", int'(error_count), 0);
        check("rst_frames", int'(frame_count), 0);
        reset = 1'b1;
        wait_lock("first");
        check("first_frames", int'(frame_count), 0);

        for (int i = 0; i < HTOT * VTOT; i++) begin
            step();
            pv_e = int'(ex < HD && ey < VD);
            check("x", int'(x), ex);
            check("y", int'(y), ey);
            check("pixel_valid", int'(pixel_valid), pv_e);
            check("rgb_out", int'(rgb_out), pv_e != 0 ? ec : 0);
            check("frame_start", int'(frame_start), int'(ex == 0 && ey == VSS));
            check("locked_run", int'(locked), 1);
            pv_n += int'(pixel_valid);
        end
        check("pv_per_frame", pv_n, HD * VD);
        step();
        check("frame_count", int'(frame_count), 1);
        check("clean_h_err", he_n, 0);
        check("clean_v_err", ve_n, 0);

        he_n = 0; ve_n = 0;
        short_hsync_line1();
        run_to(0, 3);
        check("short_h_err", he_n, 1);
        check("short_v_err", ve_n, 0);
        check("short_unlocked", int'(locked), 0);
        check("short_count", int'(error_count), 1);
        wait_lock("short");

        he_n = 0;
        run_to(0, 1);
        line_len = HTOT + 1;
        run_to(0, 2);
        line_len = HTOT;
        run_to(0, 3);
        check("long_line_h_err", he_n, 1);
        check("long_line_unlocked", int'(locked), 0);
        check("long_line_count", int'(error_count), 2);
        wait_lock("long_line");

        he_n = 0; ve_n = 0;
        run_to(0, 1);
        frame_len = VTOT + 1;
        run_to(0, 0);
        frame_len = VTOT;
        run_to(0, VSS);
        check("long_frame_v_err", ve_n, 1);
        check("long_frame_h_err", he_n, 0);
        check("long_frame_unlocked", int'(locked), 0);
        check("long_frame_count", int'(error_count), 3);
        wait_lock("long_frame");

        run_to(0, 1);
        hs_len = HS - 1;
        n = 0;
        while (!h_error && n < 2 * HTOT) begin
            step();
            n++;
        end
        check("clr_h_error_seen", int'(h_error), 1);
        clear_errors = 1'b1;
        step();
        clear_errors = 1'b0;
        hs_len = HS;
        check("clr_with_error", int'(error_count), 1);
        wait_lock("clr");

        he_n = 0;
        for (int i = 1; i <= 300; i++) begin
            short_hsync_line1();
            if (i == 253) check("sat_254", int'(error_count), 254);
            if (i == 254) check("sat_255", int'(error_count), 255);
        end
        check("sat_pulses", he_n, 300);
        check("sat_hold", int'(error_count), 255);

        run_to(0, 0);
        run_to(3, 2);
        check("pre_rst_locked", int'(locked), 1);
        reset = 1'b0;
        step();
        check("mid_rst_locked", int'(locked), 0);
        check("mid_rst_x", int'(x), 0);
        check("mid_rst_y", int'(y), 0);
        check("mid_rst_rgb", int'(rgb_out), 0);
        check("mid_rst_pv", int'(pixel_valid), 0);
        check("mid_rst_errs", int'(error_count), 0);
        check("mid_rst_frames", int'(frame_count), 0);
        reset = 1'b1;
        wait_lock("reacq");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/game_vga_timing_checker.md
Name: game_vga_timing_checker

Overview:
- Receive-side counterpart of the game_hvsync timing generator.
- Samples hsync, vsync and rgb on the pixel clock and locks onto the line and frame structure.
- Recovers x/y pixel coordinates and flags any deviation from the programmed VGA timing.
- Used in the simulation bench and on-chip as a monitor: recovered pixel stream for frame capture or checksum, error flags for debug LEDs.

Parameters:
X_WIDTH, 10, width of recovered x
Y_WIDTH, 10, width of recovered y
H_DISPLAY, 640, visible pixels per line
H_FRONT, 16, horizontal front porch
H_SYNC, 96, hsync width in clocks
H_BACK, 48, horizontal back porch
V_DISPLAY, 480, visible lines
V_BOTTOM, 10, vertical front porch (bottom border)
V_SYNC, 2, vsync width in lines
V_TOP, 33, vertical back porch (top border)
SYNC_ACTIVE, 0, active level of hsync/vsync (0 = active-low)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-low reset (reset==0 resets on the clk edge)
hsync  in  1  horizontal sync under test
vsync  in  1  vertical sync under test
rgb  in  3  pixel colour under test
clear_errors  in  1  single-cycle pulse; zeroes error_count
locked  out  1  horizontal and vertical timing locked
x  out  X_WIDTH  recovered horizontal position
y  out  Y_WIDTH  recovered vertical position
pixel_valid  out  1  locked and x<H_DISPLAY and y<V_DISPLAY
rgb_out  out  3  rgb aligned with x/y
frame_start  out  1  one-cycle pulse at the vsync assertion edge while locked
h_error  out  1  one-cycle pulse on a horizontal violation
v_error  out  1  one-cycle pulse on a vertical violation
error_count  out  8  saturating count of h_error + v_error pulses
frame_count  out  16  wrapping count of frame_start pulses

Behaviour:
- Derived constants: H_TOTAL = H_DISPLAY+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL = V_DISPLAY+V_BOTTOM+V_SYNC+V_TOP (525).
- Input stage:
  - hsync, vsync and rgb are registered once.
  - Assertion and deassertion edges are detected by comparing the registered sample with the previous sample.
- Horizontal counter hcnt:
  - On an hsync assertion edge, the cycle of that sample is assigned hcnt = H_DISPLAY+H_FRONT.
  - Otherwise hcnt increments and wraps from H_TOTAL-1 to 0.
- Vertical counter vcnt:
  - Increments when hcnt wraps; wraps from V_TOTAL-1 to 0.
  - On a vsync assertion edge, vcnt is loaded with V_DISPLAY+V_BOTTOM.
- Horizontal checks (H_ACQ, V_ACQ and LOCKED):
  - hsync deassertion must occur exactly at hcnt = H_DISPLAY+H_FRONT+H_SYNC.
  - An assertion edge must occur only when the free-running hcnt would have been H_DISPLAY+H_FRONT.
  - A missing assertion when hcnt reaches H_DISPLAY+H_FRONT is also a violation.
- Vertical checks (LOCKED only):
  - vsync deassertion must occur on the first line with vcnt = V_DISPLAY+V_BOTTOM+V_SYNC.
  - Assertion edges must be exactly V_TOTAL lines apart.
  - A missing assertion when vcnt reaches V_DISPLAY+V_BOTTOM is also a violation.
- State machine (SEARCH, H_ACQ, V_ACQ, LOCKED; reset state SEARCH):
  - SEARCH → H_ACQ on the first hsync assertion edge.
  - H_ACQ → V_ACQ after one complete line passes all horizontal checks. On a violation: stay in H_ACQ, reseed hcnt from the edge, no h_error pulse.
  - V_ACQ → LOCKED on a vsync assertion edge. A horizontal violation sends V_ACQ back to H_ACQ.
  - LOCKED, horizontal violation: h_error pulse, go to SEARCH.
  - LOCKED, vertical violation: v_error pulse, go to V_ACQ.
  - Both violations in the same cycle: both pulses, go to SEARCH.
- locked = (state==LOCKED).
- Latency: x, y, pixel_valid, rgb_out and frame_start are registered and refer to the input sample taken exactly 2 clk earlier.
- rgb_out is forced to 0 when pixel_valid is 0.
- hsync and vsync edges in the same cycle: hcnt is loaded first; vcnt is loaded for that line.
- error_count:
  - Adds 1 per cycle with h_error or v_error (at most +1 per cycle); saturates at 255.
  - clear_errors and an error in the same cycle → error_count = 1.
- frame_count increments on frame_start and wraps 65535 → 0.
- Reset (any time, including mid-frame): state SEARCH, all counters and all outputs 0 on the next clk edge.

Decomposition:
- Shared package game_vga_pkg holds:
  - default timing constants
  - H_TOTAL / V_TOTAL functions
  - sync-position constants
  - state enum (SEARCH, H_ACQ, V_ACQ, LOCKED)
- One sub-module game_sync_edge (register, previous sample, assert/deassert pulses, SYNC_ACTIVE-aware) is instantiated twice, for hsync and vsync.

Test Plan:
- Clean stream: reset 0 for 4 clk, then game_hvsync defaults drive the inputs → locked rises at the first vsync assertion edge. Afterwards x/y equal the generator x/y delayed 2 clk, pixel_valid high for 307200 cycles per frame, frame_count increments once per 420000 clk.
- One line in LOCKED with a 95-clk hsync → single h_error pulse, error_count=1, locked=0. locked returns at the next vsync assertion edge.
- Line length 801 in LOCKED → h_error at the late edge, state SEARCH, reacquire and lock within 1 frame.
- One frame of 526 lines → v_error pulse, locked=0 (V_ACQ), relock at the following vsync edge, error_count increments by 1.
- clear_errors pulsed in the same cycle as an h_error → error_count=1. Inject 300 violations → error_count holds at 255.
- reset driven low mid-frame at y=200 → next edge: locked=0, x=y=0, counts=0, rgb_out=0. Reacquire after release.
